// File: rtl/sc_udatapath_pkg.sv
// Shared definitions for the microprogrammed datapath, its controller and their bench:
// opcodes, controller state encoding and the 24-bit micro-instruction field layout.
package sc_udatapath_pkg;

    localparam int DW_BUS   = 32;
    localparam int DW_MUX   = 6;
    localparam int DW_ALU   = 4;
    localparam int DW_DEC   = 6;
    localparam int DW_PC    = 4;
    localparam int DW_OP    = 2;
    localparam int DW_INSTR = DW_OP + DW_ALU + 2 * DW_MUX + DW_DEC;

    localparam int INSTR_DEST_LSB = 0;
    localparam int INSTR_MUXB_LSB = INSTR_DEST_LSB + DW_DEC;
    localparam int INSTR_MUXA_LSB = INSTR_MUXB_LSB + DW_MUX;
    localparam int INSTR_ALU_LSB  = INSTR_MUXA_LSB + DW_MUX;
    localparam int INSTR_OP_LSB   = INSTR_ALU_LSB + DW_ALU;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_EXEC = 2'b01,
        OP_BRZ  = 2'b10,
        OP_HALT = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_DONE, ST_PAUSE
    } state_t;

    function automatic logic [DW_INSTR-1:0] make_instr(input opcode_t op,
                                                       input logic [DW_ALU-1:0] alu,
                                                       input logic [DW_MUX-1:0] muxa,
                                                       input logic [DW_MUX-1:0] muxb,
                                                       input logic [DW_DEC-1:0] dest);
        return {op, alu, muxa, muxb, dest};
    endfunction

endpackage

// File: rtl/sc_controller_pc.sv
// Program counter for the microsequencer: clear, load (branch target) or increment with
// natural wrap at 2^W-1; clear has priority over load, load over increment.
module sc_controller_pc #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic         inc_i,
    input  logic [W-1:0] ld_val_i,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr_i)      pc_d = '0;
        else if (ld_i)  pc_d = ld_val_i;
        else if (inc_i) pc_d = pc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/sc_udatapath_controller.sv
// Microsequencer for the 32-bit microprogrammed datapath (fetch/decode/execute/writeback).
// Optional SC_CONTROLLER_SINGLESTEP_EN adds Step_In and a PAUSE state after each instruction.
module sc_udatapath_controller
    import sc_udatapath_pkg::*;
#(
    parameter int DATAWIDTH_BUS               = DW_BUS,
    parameter int DATAWIDTH_MUX_SELECTION     = DW_MUX,
    parameter int DATAWIDTH_ALU_SELECTION     = DW_ALU,
    parameter int DATAWIDTH_DECODER_SELECTION = DW_DEC,
    parameter int DATAWIDTH_PC                = DW_PC,
    parameter int DATAWIDTH_INSTR             = DW_INSTR
) (
    input  logic                                   SC_CONTROLLER_CLOCK_50,
    input  logic                                   SC_CONTROLLER_Reset_InLow,
    input  logic                                   SC_CONTROLLER_Start_In,
`ifdef SC_CONTROLLER_SINGLESTEP_EN
    input  logic                                   SC_CONTROLLER_Step_In,
`endif
    input  logic [DATAWIDTH_INSTR-1:0]             SC_CONTROLLER_Instr_In,
    input  logic                                   SC_CONTROLLER_Zero_In,
    input  logic [DATAWIDTH_BUS-1:0]               SC_CONTROLLER_DataBUS_In,
    output logic [DATAWIDTH_PC-1:0]                SC_CONTROLLER_Addr_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_CONTROLLER_MuxA_Sel_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_CONTROLLER_MuxB_Sel_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_CONTROLLER_ALU_Sel_Out,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_CONTROLLER_Decoder_Sel_Out,
    output logic                                   SC_CONTROLLER_RegWrite_Out,
    output logic                                   SC_CONTROLLER_Busy_Out,
    output logic                                   SC_CONTROLLER_Done_Out,
    output logic [DATAWIDTH_BUS-1:0]               SC_CONTROLLER_Result_Out
);

    localparam int DEST_LSB = 0;
    localparam int MUXB_LSB = DEST_LSB + DATAWIDTH_DECODER_SELECTION;
    localparam int MUXA_LSB = MUXB_LSB + DATAWIDTH_MUX_SELECTION;
    localparam int ALU_LSB  = MUXA_LSB + DATAWIDTH_MUX_SELECTION;
    localparam int OP_LSB   = ALU_LSB + DATAWIDTH_ALU_SELECTION;
    localparam int IR_W     = OP_LSB;  // opcode is consumed in DECODE, so IR keeps only the fields

`ifdef SC_CONTROLLER_SINGLESTEP_EN
    localparam state_t AFTER_INSTR = ST_PAUSE;
`else
    localparam state_t AFTER_INSTR = ST_FETCH;
`endif

    state_t                    state_q, state_d;
    logic [IR_W-1:0]           ir_q, ir_d;
    logic                      flag_q, flag_d;
    logic [DATAWIDTH_BUS-1:0]  result_q, result_d;
    logic                      pc_clr, pc_ld, pc_inc;
    logic [DATAWIDTH_PC-1:0]   pc;
    opcode_t                   in_op;

    assign in_op = opcode_t'(SC_CONTROLLER_Instr_In[OP_LSB +: DW_OP]);

    sc_controller_pc #(.W(DATAWIDTH_PC)) u_pc (
        .clk      (SC_CONTROLLER_CLOCK_50),
        .rst_n    (SC_CONTROLLER_Reset_InLow),
        .clr_i    (pc_clr),
        .ld_i     (pc_ld),
        .inc_i    (pc_inc),
        .ld_val_i (SC_CONTROLLER_Instr_In[DEST_LSB +: DATAWIDTH_PC]),
        .pc_o     (pc)
    );

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        flag_d   = flag_q;
        result_d = result_q;
        pc_clr   = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        case (state_q)
            ST_IDLE: if (SC_CONTROLLER_Start_In) begin
                pc_clr  = 1'b1;
                flag_d  = 1'b0;
                state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d = SC_CONTROLLER_Instr_In[IR_W-1:0];
                case (in_op)
                    OP_NOP:  begin pc_inc = 1'b1; state_d = AFTER_INSTR; end
                    OP_BRZ:  begin
                        pc_ld   = flag_q;
                        pc_inc  = !flag_q;
                        state_d = AFTER_INSTR;
                    end
                    OP_EXEC: state_d = ST_EXECUTE;
                    OP_HALT: state_d = ST_DONE;
                endcase
            end
            ST_EXECUTE: state_d = ST_WRITEBACK;
            ST_WRITEBACK: begin
                flag_d  = SC_CONTROLLER_Zero_In;
                pc_inc  = 1'b1;
                state_d = AFTER_INSTR;
            end
            ST_DONE: begin
                result_d = SC_CONTROLLER_DataBUS_In;
                state_d  = ST_IDLE;
            end
`ifdef SC_CONTROLLER_SINGLESTEP_EN
            ST_PAUSE: if (SC_CONTROLLER_Step_In) state_d = ST_FETCH;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SC_CONTROLLER_CLOCK_50 or negedge SC_CONTROLLER_Reset_InLow) begin
        if (!SC_CONTROLLER_Reset_InLow) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            flag_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            flag_q   <= flag_d;
            result_q <= result_d;
        end
    end

    // Outputs come only from registered state/IR so the datapath sees glitch-free controls.
    always_comb begin
        SC_CONTROLLER_MuxA_Sel_Out    = '0;
        SC_CONTROLLER_MuxB_Sel_Out    = '0;
        SC_CONTROLLER_ALU_Sel_Out     = '0;
        SC_CONTROLLER_Decoder_Sel_Out = '0;
        SC_CONTROLLER_RegWrite_Out    = 1'b0;
        SC_CONTROLLER_Done_Out        = 1'b0;
        case (state_q)
            ST_EXECUTE, ST_WRITEBACK: begin
                SC_CONTROLLER_MuxA_Sel_Out = ir_q[MUXA_LSB +: DATAWIDTH_MUX_SELECTION];
                SC_CONTROLLER_MuxB_Sel_Out = ir_q[MUXB_LSB +: DATAWIDTH_MUX_SELECTION];
                SC_CONTROLLER_ALU_Sel_Out  = ir_q[ALU_LSB +: DATAWIDTH_ALU_SELECTION];
                if (state_q == ST_WRITEBACK) begin
                    SC_CONTROLLER_Decoder_Sel_Out = ir_q[DEST_LSB +: DATAWIDTH_DECODER_SELECTION];
                    SC_CONTROLLER_RegWrite_Out    = 1'b1;
                end
            end
            ST_DONE: SC_CONTROLLER_Done_Out = 1'b1;
            default: ;
        endcase
    end

    assign SC_CONTROLLER_Busy_Out   = (state_q != ST_IDLE);
    assign SC_CONTROLLER_Addr_Out   = pc;
    assign SC_CONTROLLER_Result_Out = result_q;

endmodule

// File: tb/tb_sc_udatapath_controller.sv
// Bench for sc_udatapath_controller: directed programs plus random forward-branching programs
// checked against an instruction-level timing model. Honors SC_CONTROLLER_SINGLESTEP_EN.
module tb_sc_udatapath_controller;
    import sc_udatapath_pkg::*;

`ifdef SC_CONTROLLER_SINGLESTEP_EN
    localparam int P = 1;
    logic step = 1'b1;
`else
    localparam int P = 0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, zero;
    logic [23:0] instr = '0;
    logic [31:0] bus = '0;
    logic [3:0]  addr;
    logic [5:0]  muxa, muxb, dec;
    logic [3:0]  alu;
    logic        regwrite, busy, done;
    logic [31:0] result;

    sc_udatapath_controller dut (
        .SC_CONTROLLER_CLOCK_50        (clk),
        .SC_CONTROLLER_Reset_InLow     (rst_n),
        .SC_CONTROLLER_Start_In        (start),
`ifdef SC_CONTROLLER_SINGLESTEP_EN
        .SC_CONTROLLER_Step_In         (step),
`endif
        .SC_CONTROLLER_Instr_In        (instr),
        .SC_CONTROLLER_Zero_In         (zero),
        .SC_CONTROLLER_DataBUS_In      (bus),
        .SC_CONTROLLER_Addr_Out        (addr),
        .SC_CONTROLLER_MuxA_Sel_Out    (muxa),
        .SC_CONTROLLER_MuxB_Sel_Out    (muxb),
        .SC_CONTROLLER_ALU_Sel_Out     (alu),
        .SC_CONTROLLER_Decoder_Sel_Out (dec),
        .SC_CONTROLLER_RegWrite_Out    (regwrite),
        .SC_CONTROLLER_Busy_Out        (busy),
        .SC_CONTROLLER_Done_Out        (done),
        .SC_CONTROLLER_Result_Out      (result)
    );

    always #5 clk = ~clk;

    // Synchronous program memory; Zero_In of the k-th EXEC of a run comes from zseq[k].
    logic [23:0] mem [16];
    logic        zseq [32];
    int          exec_cnt = 0, zbase = 0;
    logic [4:0]  zi;
    always @(posedge clk) instr <= mem[addr];
    always @(posedge clk) if (regwrite) exec_cnt <= exec_cnt + 1;
    assign zi   = 5'(exec_cnt - zbase);
    assign zero = zseq[zi];

    typedef struct packed {
        logic [15:0] cyc;
        logic [3:0]  pc;
        logic [3:0]  alu;
        logic [5:0]  a, b, d;
    } ev_t;

    ev_t exp_q[$], obs_q[$];
    int  exp_done, exp_dpc, obs_done, obs_dpc;
    int  tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level model: cycle offsets from the Start sample, PC and flag per instruction.
    task automatic model();
        int pc = 0, t = 0, n = 0;
        bit flag = 0;
        logic [23:0] w;
        exp_q.delete();
        exp_done = -1;
        exp_dpc  = -1;
        for (int s = 0; s < 64; s++) begin
            w = mem[pc];
            if (w[23:22] == OP_EXEC) begin
                exp_q.push_back('{cyc: 16'(t + 4), pc: 4'(pc), alu: w[21:18],
                                  a: w[17:12], b: w[11:6], d: w[5:0]});
                flag = zseq[n % 32];
                n++;
                pc = (pc + 1) % 16;
                t += 4 + P;
            end else if (w[23:22] == OP_NOP) begin
                pc = (pc + 1) % 16;
                t += 2 + P;
            end else if (w[23:22] == OP_BRZ) begin
                pc = flag ? int'(w[3:0]) : (pc + 1) % 16;
                t += 2 + P;
            end else begin
                exp_done = t + 3;
                exp_dpc  = pc;
                break;
            end
        end
    endtask

    task automatic run(input bit pulse_mid);
        int n;
        model();
        zbase = exec_cnt;
        obs_q.delete();
        obs_done = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (pulse_mid) start = (k == 3);
            chk("busy_run", busy, 1'b1);
            if (regwrite)
                obs_q.push_back('{cyc: 16'(k), pc: addr, alu: alu, a: muxa, b: muxb, d: dec});
            else
                chk("dec_idle", dec, 6'd0);
            if (done) begin
                obs_done = k;
                obs_dpc  = addr;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", obs_done >= 0, 1'b1);
        chk("n_regwrite", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("regwrite_ev", obs_q[i], exp_q[i]);
        chk("done_cycle", obs_done, exp_done);
        chk("done_pc", obs_dpc, exp_dpc);
        @(negedge clk);
        chk("result", result, bus);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = make_instr(OP_HALT, 4'h0, 6'h0, 6'h0, 6'h0);
        for (int i = 0; i < 32; i++) zseq[i] = 1'b0;
    endtask

    int r, found;

    initial begin
        clear_mem();
        // Reset state
        #12;
        chk("rst_addr", addr, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_regwrite", regwrite, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_sel", {muxa, muxb, alu, dec}, 22'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: EXEC then HALT
        mem[0] = make_instr(OP_EXEC, 4'd2, 6'd1, 6'd2, 6'd5);
        mem[1] = make_instr(OP_HALT, 4'd0, 6'd0, 6'd0, 6'd0);
        bus = 32'h000000A5;
        run(1'b0);
        chk("t1_dec", obs_q.size() > 0 ? obs_q[0].d : 6'h3F, 6'd5);
        chk("t1_alu", obs_q.size() > 0 ? obs_q[0].alu : 4'hF, 4'd2);
        chk("t1_muxab", obs_q.size() > 0 ? {obs_q[0].a, obs_q[0].b} : 12'hFFF, {6'd1, 6'd2});
        chk("t1_done7", obs_done, 7 + P);
        chk("t1_result", result, 32'h000000A5);

        // 2: BRZ taken / not taken after an EXEC
        mem[1] = make_instr(OP_BRZ, 4'd0, 6'd0, 6'd0, 6'd7);
        zseq[0] = 1'b1;
        run(1'b0);
        chk("t2_taken_pc", obs_dpc, 7);
        zseq[0] = 1'b0;
        run(1'b0);
        chk("t2_fall_pc", obs_dpc, 2);

        // 3: NOP at 15 wraps to 0; second pass through BRZ falls through to HALT at 2
        mem[1]  = make_instr(OP_BRZ, 4'd0, 6'd0, 6'd0, 6'd15);
        mem[15] = make_instr(OP_NOP, 4'd0, 6'd0, 6'd0, 6'd0);
        zseq[0] = 1'b1;
        zseq[1] = 1'b0;
        run(1'b0);
        chk("t3_two_exec", obs_q.size(), 2);
        chk("t3_wrap_pc", obs_q.size() == 2 ? obs_q[1].pc : 4'hF, 4'd0);
        chk("t3_done_pc", obs_dpc, 2);

        // 4: Start during EXECUTE ignored; Start held re-enters after DONE
        clear_mem();
        mem[0] = make_instr(OP_EXEC, 4'd9, 6'd3, 6'd4, 6'd11);
        bus = 32'h1234_5678;
        run(1'b1);
        start = 1'b1;
        found = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) begin found = 1; break; end
        end
        chk("t4_held_done", found, 1);
        @(negedge clk);
        chk("t4_idle_gap", busy, 1'b0);
        @(negedge clk);
        chk("t4_reenter", busy, 1'b1);
        chk("t4_reenter_pc", addr, 4'd0);
        start = 1'b0;

        // 5: async reset in EXECUTE
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        zbase = exec_cnt;
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_exec_alu", alu, 4'd9);
        rst_n = 1'b0;
        #1;
        chk("t5_async_sel", {muxa, muxb, alu, dec}, 22'd0);
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_rw", {regwrite, done}, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        found = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (regwrite || done || busy) found++;
        end
        chk("t5_quiet", found, 0);

        // Random forward-branching programs
        for (int p = 0; p < 10; p++) begin
            for (int a = 0; a < 15; a++) begin
                r = $urandom_range(0, 9);
                mem[a] = make_instr(r < 2 ? OP_NOP : r < 7 ? OP_EXEC : r < 9 ? OP_BRZ : OP_HALT,
                                    4'($urandom), 6'($urandom), 6'($urandom),
                                    r >= 7 && r < 9 ? 6'($urandom_range(a + 1, 15)) : 6'($urandom));
            end
            mem[15] = make_instr(OP_HALT, 4'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
            for (int i = 0; i < 32; i++) zseq[i] = 1'($urandom);
            bus = $urandom;
            run(1'($urandom));
        end

`ifdef SC_CONTROLLER_SINGLESTEP_EN
        // 6: single-step holds in PAUSE until Step_In
        clear_mem();
        mem[0] = make_instr(OP_EXEC, 4'd1, 6'd1, 6'd1, 6'd1);
        mem[1] = make_instr(OP_EXEC, 4'd2, 6'd2, 6'd2, 6'd2);
        step = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (regwrite) found++;
        end
        chk("t6_first_pause_rw", found, 1);
        chk("t6_pause_pc", addr, 4'd1);
        chk("t6_pause_busy", busy, 1'b1);
        step = 1'b1;
        @(negedge clk) step = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (regwrite) found++;
        end
        chk("t6_two_rw", found, 2);
        chk("t6_pause2_pc", addr, 4'd2);
        step = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin found = 1; break; end
        end
        chk("t6_done", found, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
